fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage, directly upstream of the instruction memory.
- Owns the program counter and drives the memory's word address and enable.
- Samples the returned word, which arrives combinationally in the same cycle, into an IF/ID pipeline register for the decoder.
- Handles decode stalls, execute-stage branch redirects, wrap at the end of the memory, and a halt instruction.

Parameters:
- MEM_DEPTH, 32: instruction memory depth in words. Must be a power of 2.
- RESET_PC, 0: word address fetched first after reset.
- HALT_WORD, 32'hFFFF_FFFF: encoding that halts fetch.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- pc_address  out  32  word index to the instruction memory; equals the internal PC register.
- imem_enable  out  1  instruction memory read enable.
- instruction_set  in  32  word read from memory at pc_address, valid in the same cycle.
- stall  in  1  decode cannot accept this cycle; holds PC and IF/ID.
- branch_valid  in  1  redirect request from execute, valid for one cycle.
- branch_target  in  32  word address for the redirect.
- if_valid  out  1  IF/ID register holds a live instruction.
- if_instruction  out  32  registered instruction.
- if_pc  out  32  word address of if_instruction.
- if_pc_plus1  out  32  (if_pc + 1) mod MEM_DEPTH.
- halted  out  1  high while in state HALT.
- fetch_count  out  32  number of instructions delivered; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (async, rst=0):
  - PC = RESET_PC; state = BOOT.
  - if_valid, if_instruction, if_pc, if_pc_plus1 and fetch_count all 0.
  - Takes effect immediately, including mid-operation and while stalled or halted.
- States:
  - BOOT: imem_enable=0, if_valid=0. Always goes to RUN on the next edge.
  - RUN: imem_enable=1.
  - HALT: imem_enable=0, halted=1.
- Address arithmetic:
  - All PC values are taken modulo MEM_DEPTH; only the low log2(MEM_DEPTH) bits are kept, upper bits are 0.
  - PC = MEM_DEPTH-1 advances to 0.
  - branch_target is masked the same way.
- Priority each edge: branch_valid > stall > normal advance.
- Branch (any state, any stall value):
  - PC <= masked branch_target.
  - if_valid <= 0 (flushes the wrong-path word).
  - State <= RUN.
  - fetch_count unchanged.
- RUN, stall=1, no branch: PC, IF/ID contents and if_valid all hold.
- RUN, stall=0, no branch:
  - IF/ID <= {instruction_set, PC, PC+1 mod MEM_DEPTH}; if_valid <= 1.
  - fetch_count <= fetch_count + 1 (saturating).
  - If instruction_set == HALT_WORD: PC holds and state <= HALT. The halt word is still delivered.
  - Otherwise PC <= PC+1 mod MEM_DEPTH.
- HALT, no branch:
  - stall=0: if_valid <= 0.
  - stall=1: IF/ID holds.
  - PC holds; only a branch leaves HALT.
- Latency:
  - The word at address A appears on if_instruction one edge after the cycle in which pc_address=A and stall=0.
  - First valid instruction: second rising edge after rst deasserts (BOOT edge, then capture edge).
- Simultaneous stall and branch: the branch wins; the bubble is inserted even though decode is stalled.

Test Plan:
1. Reset release, stall=0, memory word = address+0x100 -> edge 1: imem_enable=1, pc_address=0, if_valid=0; edge 2: if_valid=1, if_instruction=0x100, if_pc=0, if_pc_plus1=1; edge 3: if_pc=1, fetch_count=2.
2. Stall for 3 cycles while if_pc=4 -> pc_address=5 and IF/ID unchanged throughout, fetch_count constant; on release, next edge gives if_pc=5.
3. branch_valid=1, branch_target=0x2A while stall=1 at PC=7 -> next edge: pc_address=0x0A (masked), if_valid=0; following edge: if_pc=0x0A, if_valid=1.
4. Sequential run through 31 -> if_pc=31 with if_pc_plus1=0; the next capture gives if_pc=0, no X on pc_address.
5. HALT_WORD stored at address 3 -> captured with if_valid=1 and halted=1; pc_address stays 3 and imem_enable=0; the next unstalled edge gives if_valid=0; branch_valid to 0 -> RUN resumes at 0.
6. Drive rst=0 mid-run at PC=9 between clock edges -> all outputs reset immediately without waiting for a clock; fetch_count=0, pc_address=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address/enable
// and captures the returned word into the IF/ID register with its PC and PC+1.
module fetch_unit #(
  parameter int          MEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_address,
  output logic        imem_enable,
  input  logic [31:0] instruction_set,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus1,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  // Keep only the in-range address bits so every PC stays inside the memory.
  function automatic logic [31:0] wrap_addr(input logic [31:0] a);
    logic [31:0] r;
    r         = '0;
    r[AW-1:0] = a[AW-1:0];
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  state_t      state, state_nxt;
  logic [31:0] pc_p0, pc_nxt;
  logic        vld_p1, vld_nxt;
  logic [31:0] ins_p1, ins_nxt;
  logic [31:0] ipc_p1, ipc_nxt;
  logic [31:0] ipc1_p1, ipc1_nxt;
  logic [31:0] cnt_p1, cnt_nxt;
  logic [31:0] pc_inc;

  assign pc_inc = wrap_addr(pc_p0 + 32'd1);

  // Branch beats stall beats advance; a branch also bubbles a stalled decoder.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_p0;
    vld_nxt   = vld_p1;
    ins_nxt   = ins_p1;
    ipc_nxt   = ipc_p1;
    ipc1_nxt  = ipc1_p1;
    cnt_nxt   = cnt_p1;
    if (branch_valid) begin
      pc_nxt    = wrap_addr(branch_target);
      vld_nxt   = 1'b0;
      state_nxt = RUN;
    end else begin
      case (state)
        BOOT: state_nxt = RUN;
        RUN: begin
          if (!stall) begin
            ins_nxt  = instruction_set;
            ipc_nxt  = pc_p0;
            ipc1_nxt = pc_inc;
            vld_nxt  = 1'b1;
            cnt_nxt  = sat_inc(cnt_p1);
            if (instruction_set == HALT_WORD) begin
              state_nxt = HALT;
            end else begin
              pc_nxt = pc_inc;
            end
          end
        end
        HALT: begin
          if (!stall) vld_nxt = 1'b0;
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  // p0: program counter and fetch state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      pc_p0 <= wrap_addr(RESET_PC);
    end else begin
      state <= state_nxt;
      pc_p0 <= pc_nxt;
    end
  end

  // p1: IF/ID register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      ins_p1  <= '0;
      ipc_p1  <= '0;
      ipc1_p1 <= '0;
      cnt_p1  <= '0;
    end else begin
      vld_p1  <= vld_nxt;
      ins_p1  <= ins_nxt;
      ipc_p1  <= ipc_nxt;
      ipc1_p1 <= ipc1_nxt;
      cnt_p1  <= cnt_nxt;
    end
  end

  assign pc_address     = pc_p0;
  assign imem_enable    = (state == RUN);
  assign halted         = (state == HALT);
  assign if_valid       = vld_p1;
  assign if_instruction = ins_p1;
  assign if_pc          = ipc_p1;
  assign if_pc_plus1    = ipc1_p1;
  assign fetch_count    = cnt_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model predicts every post-edge output,
// a monitor compares the DUT one time unit after each rising edge.
module tb_fetch_unit;

  localparam int          D  = 32;
  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, stall, branch_valid;
  logic [31:0] branch_target, pc_address, instruction_set;
  logic        imem_enable, if_valid, halted;
  logic [31:0] if_instruction, if_pc, if_pc_plus1, fetch_count;
  logic [31:0] mem [0:D-1];

  assign instruction_set = mem[pc_address[4:0]];

  fetch_unit #(.MEM_DEPTH(D), .RESET_PC(32'h0), .HALT_WORD(HW)) dut (
    .clk(clk), .rst(rst), .pc_address(pc_address), .imem_enable(imem_enable),
    .instruction_set(instruction_set), .stall(stall), .branch_valid(branch_valid),
    .branch_target(branch_target), .if_valid(if_valid), .if_instruction(if_instruction),
    .if_pc(if_pc), .if_pc_plus1(if_pc_plus1), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        en;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] ipc;
    logic [31:0] ipc1;
    logic        hlt;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: mode 0=boot, 1=run, 2=halt
  int          m_mode;
  logic [31:0] m_pc, m_ins, m_ipc, m_ipc1, m_cnt;
  logic        m_vld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_vld = 1'b0;
    m_ins = '0; m_ipc = '0; m_ipc1 = '0; m_cnt = '0;
  endtask

  task automatic model_step(input logic s, input logic b, input logic [31:0] t);
    logic [31:0] word;
    word = mem[m_pc];
    if (b) begin
      m_pc   = t % 32'(D);
      m_vld  = 1'b0;
      m_mode = 1;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1 && !s) begin
      m_ins  = word;
      m_ipc  = m_pc;
      m_ipc1 = (m_pc + 1) % 32'(D);
      m_vld  = 1'b1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (word == HW) m_mode = 2;
      else m_pc = (m_pc + 1) % 32'(D);
    end else if (m_mode == 2 && !s) begin
      m_vld = 1'b0;
    end
  endtask

  // Drive one cycle of inputs (called at a falling edge), predict, and queue the expectation.
  task automatic cycle(input logic s, input logic b, input logic [31:0] t);
    exp_t e;
    stall = s; branch_valid = b; branch_target = t;
    model_step(s, b, t);
    e.pc = m_pc; e.en = (m_mode == 1); e.vld = m_vld; e.ins = m_ins;
    e.ipc = m_ipc; e.ipc1 = m_ipc1; e.hlt = (m_mode == 2); e.cnt = m_cnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Asserts reset between clock edges and checks it takes effect without an edge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_pc_address", pc_address, 32'h0);
    check("rst_imem_enable", 32'(imem_enable), 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_instruction", if_instruction, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_pc_plus1", if_pc_plus1, 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_fetch_count", fetch_count, 32'h0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pc_address", pc_address, mon_e.pc);
      check("imem_enable", 32'(imem_enable), 32'(mon_e.en));
      check("if_valid", 32'(if_valid), 32'(mon_e.vld));
      check("if_instruction", if_instruction, mon_e.ins);
      check("if_pc", if_pc, mon_e.ipc);
      check("if_pc_plus1", if_pc_plus1, mon_e.ipc1);
      check("halted", 32'(halted), 32'(mon_e.hlt));
      check("fetch_count", fetch_count, mon_e.cnt);
    end
  end

  task automatic fill_linear();
    for (int i = 0; i < D; i++) mem[i] = 32'h100 + 32'(i);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; branch_valid = 1'b0; branch_target = '0;
    fill_linear();
    do_reset();

    // Boot edge, first capture, second capture
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);

    // Hold while if_pc=4
    for (int i = 0; i < 8 && !(m_vld && m_ipc == 4); i++) cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);

    // Branch with stall at PC=7, target masked to 0x0A
    for (int i = 0; i < 8 && m_pc != 7; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h2A);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);

    // Sequential wrap past the last word
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, '0);

    // Halt word at address 3
    mem[3] = HW;
    cycle(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    mem[3] = 32'h103;
    cycle(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0);

    // Randomized run with sprinkled halt words, stalls and redirects
    for (int i = 0; i < D; i++) begin
      logic [31:0] r;
      r = $urandom;
      if (r == HW) r = 32'h0;
      mem[i] = ($urandom_range(0, 9) == 0) ? HW : r;
    end
    for (int i = 0; i < 3000; i++) begin
      logic s, b;
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 8);
      cycle(s, b, $urandom);
    end

    // Asynchronous reset mid-run at PC=9
    fill_linear();
    cycle(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 20 && !(m_pc == 9 && m_mode == 1); i++) cycle(1'b0, 1'b0, '0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
